lab_calc_sweeper: RTL and testbench
===================================

Name: lab_calc_sweeper

Overview:
- Upstream stimulus and capture stage for the 4-input lab calculator (inputs D, C, A, B; outputs Y, Z).
- Walks the 16 input combinations in the order D C A B = 0000..1111 (D MSB, B LSB) and holds each vector for a programmable dwell.
- Samples the calculator's Y/Z at the end of each dwell and builds a 16-entry truth-table register for the board display and for the self-check logic.
- Supports a free-running sweep or a single-step mode driven by a debounced push-button pulse.

Parameters:
DWELL_CYCLES, 10, clock cycles each vector is driven before sampling; legal range 1..65535
CNT_W, $clog2(DWELL_CYCLES+1), dwell counter width; derived, never overridden

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  one-cycle pulse; begins a sweep from IDLE or DONE
step_mode  input  1  1 = pause after each sample until step; sampled on the start cycle only
step  input  1  one-cycle pulse; advances to the next vector while in HOLD
calc_d  output  1  calculator input D = idx[3]
calc_c  output  1  calculator input C = idx[2]
calc_a  output  1  calculator input A = idx[1]
calc_b  output  1  calculator input B = idx[0]
calc_y  input  1  calculator output Y (combinational return)
calc_z  input  1  calculator output Z (combinational return)
idx  output  4  current vector index
busy  output  1  high in DRIVE, SAMPLE and HOLD
done  output  1  high in DONE
table_y  output  16  bit k = Y captured for vector k
table_z  output  16  bit k = Z captured for vector k

Behaviour:
- Clocking and reset: single clock, synchronous active-low reset rst_n, as fixed above. While rst_n=0 at a clock edge, all state clears: state=IDLE, idx=0, dwell count=0, table_y=table_z=0, busy=0, done=0, calc_* = 0. Reset mid-sweep aborts with no partial result kept.
- States (shared enum): IDLE, DRIVE, SAMPLE, HOLD, DONE.
- IDLE:
  - start=1 -> DRIVE; idx=0; count=0; both tables cleared; step_mode latched.
- DRIVE:
  - calc_* = idx, held stable for the whole state.
  - count increments each cycle.
  - When count == DWELL_CYCLES-1 -> SAMPLE (the vector is driven for exactly DWELL_CYCLES cycles).
- SAMPLE (1 cycle):
  - table_y[idx] <= calc_y; table_z[idx] <= calc_z; count cleared.
  - If idx==15 -> DONE.
  - Else if latched step_mode -> HOLD.
  - Else idx <= idx+1 and -> DRIVE.
- HOLD:
  - calc_* keep the last vector.
  - step=1 -> idx <= idx+1, -> DRIVE.
  - start is ignored.
- DONE:
  - idx stays 15; tables hold their values.
  - start=1 -> same action as in IDLE (restart).
- Timing: free-run sweep takes 16*(DWELL_CYCLES+1) cycles from the start edge; done=1 on the following cycle.
- No wrap-around: idx never rolls past 15.
- Simultaneous or stray events:
  - start while busy is ignored.
  - step outside HOLD is ignored.
  - start and step in the same cycle in HOLD: step wins.
- Outputs are registered state decodes. calc_* are glitch-free, changing only on the DRIVE entry edge.

Decomposition:
- lab_calc_pkg holds the state enum typedef, NUM_VECTORS=16 and IDX_W=4.
- One sub-module, lab_calc_dwell_timer: parameterised counter with clear/enable inputs and a terminal-count output.
- Capture, indexing and the FSM stay in the top module.

Test Plan:
- Reset with DWELL_CYCLES=2: rst_n=0 for 2 cycles mid-sweep -> busy=0, done=0, idx=0, tables=0x0000 the next cycle.
- Free run, DWELL_CYCLES=2, bench model Y=A^B, Z=D&C: start -> done after exactly 48 cycles; table_y=0x6666; table_z=0xF000.
- Dwell check, DWELL_CYCLES=10: calc_* stays 4'b0101 for exactly 10 cycles; SAMPLE follows; idx then goes to 6.
- Step mode, same bench model: after the first sample, state=HOLD with idx=0 for 20 idle cycles; a step pulse gives idx=1 three cycles later in SAMPLE; stray steps in DRIVE have no effect.
- Start during busy, then restart from DONE: the mid-sweep start does not disturb idx; the start in DONE clears the tables to 0x0000 and done=0, and the sweep reruns with the same results.
- Model Y constant 1, Z constant 0 -> table_y=0xFFFF, table_z=0x0000 (capture-bit ordering check).

Source files
------------

// File: rtl/lab_calc_sweeper_pkg.sv
// lab_calc_pkg: shared types and sizes for the lab calculator sweeper.
// Rev 1.0
`default_nettype none

package lab_calc_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_DRIVE  = ST_DRIVE,
    S_SAMPLE = ST_SAMPLE,
    S_HOLD   = ST_HOLD,
    S_DONE   = ST_DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lab_calc_sweeper_if.sv
// lab_calc_sweeper_if: stimulus/return bundle between sweeper and calculator.
// Rev 1.0
`default_nettype none

interface lab_calc_sweeper_if;
  logic calc_d;
  logic calc_c;
  logic calc_a;
  logic calc_b;
  logic calc_y;
  logic calc_z;

  modport master (
    output calc_d, calc_c, calc_a, calc_b,
    input  calc_y, calc_z
  );

  modport slave (
    input  calc_d, calc_c, calc_a, calc_b,
    output calc_y, calc_z
  );
endinterface

`default_nettype wire

// File: rtl/lab_calc_sweeper_dwell_timer.sv
// lab_calc_dwell_timer: clearable up-counter flagging the last dwell cycle.
// Rev 1.0
`default_nettype none

module lab_calc_dwell_timer #(
  parameter int MAX_COUNT = 10,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clear,
  input  wire logic enable,
  output logic      terminal
);

  localparam logic [CNT_W-1:0] c_terminal = CNT_W'(MAX_COUNT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign terminal = (r_count == c_terminal);

endmodule

`default_nettype wire

// File: rtl/lab_calc_sweeper.sv
// lab_calc_sweeper: walks the 16 calculator input vectors and captures Y/Z truth tables.
// Rev 1.0
`default_nettype none

module lab_calc_sweeper
  import lab_calc_pkg::*;
#(
  parameter int DWELL_CYCLES = 10,
  parameter int CNT_W        = $clog2(DWELL_CYCLES + 1)
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   start,
  input  wire logic                   step_mode,
  input  wire logic                   step,
  lab_calc_sweeper_if.master          calc,
  output logic [IDX_W-1:0]            idx,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_VECTORS-1:0]      table_y,
  output logic [NUM_VECTORS-1:0]      table_z
);

  state_e                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_step_mode;
  logic [NUM_VECTORS-1:0] r_table_y;
  logic [NUM_VECTORS-1:0] r_table_z;

  logic w_start_ok;
  logic w_clear;
  logic w_enable;
  logic w_terminal;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_clear    = w_start_ok || (r_state == S_SAMPLE);
  assign w_enable   = (r_state == S_DRIVE);

  lab_calc_dwell_timer #(
    .MAX_COUNT (DWELL_CYCLES),
    .CNT_W     (CNT_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_clear),
    .enable   (w_enable),
    .terminal (w_terminal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_step_mode <= 1'b0;
      r_table_y   <= '0;
      r_table_z   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_DRIVE;
            r_idx       <= '0;
            r_step_mode <= step_mode;
            r_table_y   <= '0;
            r_table_z   <= '0;
          end
        end
        S_DRIVE: begin
          if (w_terminal) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_table_y[r_idx] <= calc.calc_y;
          r_table_z[r_idx] <= calc.calc_z;
          if (r_idx == IDX_W'(NUM_VECTORS - 1)) begin
            r_state <= S_DONE;
          end else if (r_step_mode) begin
            r_state <= S_HOLD;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_DRIVE;
          end
        end
        S_HOLD: begin
          // step takes priority; start is never honoured here
          if (step) begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_DRIVE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Vector pins follow the index register, so they only move on DRIVE entry
  assign calc.calc_d = r_idx[3];
  assign calc.calc_c = r_idx[2];
  assign calc.calc_a = r_idx[1];
  assign calc.calc_b = r_idx[0];

  assign idx     = r_idx;
  assign busy    = (r_state == S_DRIVE) || (r_state == S_SAMPLE) || (r_state == S_HOLD);
  assign done    = (r_state == S_DONE);
  assign table_y = r_table_y;
  assign table_z = r_table_z;

endmodule

`default_nettype wire

// File: tb/tb_lab_calc_sweeper.sv
// tb_lab_calc_sweeper: directed scoreboard bench for lab_calc_sweeper.
// Rev 1.0
`default_nettype none

module tb_lab_calc_sweeper;

  localparam int DWELL_A = 2;
  localparam int DWELL_B = 10;

  logic clk;
  logic rst_n;
  logic start_a, step_mode_a, step_a;
  logic start_b;
  logic [3:0]  idx_a, idx_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] table_y_a, table_z_a, table_y_b, table_z_b;
  int          mode_a;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  lab_calc_sweeper_if ifa ();
  lab_calc_sweeper_if ifb ();

  lab_calc_sweeper #(.DWELL_CYCLES(DWELL_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .step_mode(step_mode_a), .step(step_a),
    .calc(ifa), .idx(idx_a), .busy(busy_a), .done(done_a),
    .table_y(table_y_a), .table_z(table_z_a)
  );

  lab_calc_sweeper #(.DWELL_CYCLES(DWELL_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .step_mode(1'b0), .step(1'b0),
    .calc(ifb), .idx(idx_b), .busy(busy_b), .done(done_b),
    .table_y(table_y_b), .table_z(table_z_b)
  );

  // Calculator model: mode 0 -> Y=A^B, Z=D&C ; mode 1 -> Y=1, Z=0
  function automatic logic [1:0] calc_model(input int mode, input logic [3:0] v);
    if (mode == 1) return 2'b10;
    return {v[1] ^ v[0], v[3] & v[2]};
  endfunction

  function automatic logic [31:0] exp_table(input int mode);
    logic [15:0] y;
    logic [15:0] z;
    logic [1:0]  r;
    y = '0;
    z = '0;
    for (int k = 0; k < 16; k++) begin
      r    = calc_model(mode, 4'(k));
      y[k] = r[1];
      z[k] = r[0];
    end
    return {y, z};
  endfunction

  always_comb {ifa.calc_y, ifa.calc_z} = calc_model(mode_a, {ifa.calc_d, ifa.calc_c, ifa.calc_a, ifa.calc_b});
  always_comb {ifb.calc_y, ifb.calc_z} = calc_model(0, {ifb.calc_d, ifb.calc_c, ifb.calc_a, ifb.calc_b});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check(tag, {table_y_a, table_z_a}, e);
    end
  endtask

  task automatic run_to_done_a(output int n);
    n = 0;
    while (done_a !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_start_a(input logic sm);
    start_a     = 1'b1;
    step_mode_a = sm;
    tick(1);
    start_a     = 1'b0;
    step_mode_a = 1'b0;
  endtask

  task automatic pulse_step_a();
    step_a = 1'b1;
    tick(1);
    step_a = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    rst_n = 1'b0; start_a = 1'b0; step_mode_a = 1'b0; step_a = 1'b0; start_b = 1'b0;
    mode_a = 0;
    tick(2);
    rst_n = 1'b1;

    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_done", 32'(done_a), 32'd0);
    check("reset_idx", 32'(idx_a), 32'd0);
    check("reset_calc", 32'({ifa.calc_d, ifa.calc_c, ifa.calc_a, ifa.calc_b}), 32'd0);
    check("reset_tables", {table_y_a, table_z_a}, 32'd0);

    // Mid-sweep reset: three vectors sampled after 10 cycles
    pulse_start_a(1'b0);
    tick(10);
    check("partial_idx", 32'(idx_a), 32'd3);
    check("partial_table_y", 32'(table_y_a), 32'h0006);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_idx", 32'(idx_a), 32'd0);
    check("abort_tables", {table_y_a, table_z_a}, 32'd0);

    // Free run: latency from the start edge and captured tables
    pulse_start_a(1'b0);
    sb_q.push_back(exp_table(0));
    run_to_done_a(n);
    check("freerun_latency", 32'(n), 32'(16 * (DWELL_A + 1)));
    check("freerun_done", 32'(done_a), 32'd1);
    check("freerun_busy", 32'(busy_a), 32'd0);
    check("freerun_idx", 32'(idx_a), 32'd15);
    check("freerun_table_lit", {table_y_a, table_z_a}, 32'h6666_F000);
    sb_check("freerun_table");

    // Dwell on the long-dwell instance: vector 5 held through DRIVE plus the SAMPLE cycle
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    n = 0;
    while ({ifb.calc_d, ifb.calc_c, ifb.calc_a, ifb.calc_b} != 4'd5 && n < 500) begin
      tick(1);
      n++;
    end
    cnt = 0;
    while ({ifb.calc_d, ifb.calc_c, ifb.calc_a, ifb.calc_b} == 4'd5 && cnt < 100) begin
      check("dwell_busy", 32'(busy_b), 32'd1);
      tick(1);
      cnt++;
    end
    check("dwell_cycles", 32'(cnt), 32'(DWELL_B + 1));
    check("dwell_next_idx", 32'(idx_b), 32'd6);
    n = 0;
    while (done_b !== 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    check("dwell_b_done", 32'(done_b), 32'd1);
    check("dwell_b_tables", {table_y_b, table_z_b}, 32'h6666_F000);

    // Step mode from DONE
    pulse_start_a(1'b1);
    sb_q.push_back(exp_table(0));
    tick(3);
    tick(20);
    check("hold_idx", 32'(idx_a), 32'd0);
    check("hold_busy", 32'(busy_a), 32'd1);
    check("hold_done", 32'(done_a), 32'd0);
    pulse_step_a();
    pulse_step_a();          // stray step while in DRIVE
    tick(2);
    check("step_idx", 32'(idx_a), 32'd1);
    check("step_table_y", 32'(table_y_a), 32'h0002);
    pulse_start_a(1'b0);     // start in HOLD is ignored
    check("hold_start_idx", 32'(idx_a), 32'd1);
    check("hold_start_busy", 32'(busy_a), 32'd1);
    step_a = 1'b1; start_a = 1'b1;
    tick(1);
    step_a = 1'b0; start_a = 1'b0;
    check("step_wins_idx", 32'(idx_a), 32'd2);
    pulse_start_a(1'b0);     // start while busy in DRIVE
    check("busy_start_idx", 32'(idx_a), 32'd2);
    tick(2);
    for (int k = 3; k < 16; k++) begin
      pulse_step_a();
      tick(3);
    end
    check("step_done", 32'(done_a), 32'd1);
    sb_check("step_table");

    // Restart from DONE, with a stray start mid-sweep
    pulse_start_a(1'b0);
    sb_q.push_back(exp_table(0));
    check("restart_done", 32'(done_a), 32'd0);
    check("restart_tables", {table_y_a, table_z_a}, 32'd0);
    check("restart_idx", 32'(idx_a), 32'd0);
    tick(4);
    pulse_start_a(1'b0);
    check("midsweep_start_idx", 32'(idx_a), 32'd1);
    run_to_done_a(n);
    check("restart_finish", 32'(done_a), 32'd1);
    sb_check("restart_table");

    // Constant model: capture bit ordering
    mode_a = 1;
    pulse_start_a(1'b0);
    sb_q.push_back(exp_table(1));
    run_to_done_a(n);
    check("const_finish", 32'(done_a), 32'd1);
    check("const_table_lit", {table_y_a, table_z_a}, 32'hFFFF_0000);
    sb_check("const_table");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
